// File: rtl/corr_pkg.sv
// Shared types and helpers for the correlation search sequencer.
package corr_pkg;

    localparam int unsigned COORD_W_DEF = 13;
    localparam int unsigned CORR_W_DEF  = 32;
    localparam int unsigned STEP_W      = 4;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        WAIT    = 3'd2,
        ADVANCE = 3'd3,
        DONE    = 3'd4
    } stateT;

    // A zero stride would never leave the window, so it is promoted to 1.
    function automatic logic [STEP_W-1:0] stepNorm(input logic [STEP_W-1:0] s);
        return (s == '0) ? STEP_W'(1) : s;
    endfunction

endpackage

// File: rtl/corr_argmax.sv
// Running argmax of correlation scores; the first score after a clear is always taken,
// later ones only when strictly greater, so ties keep the earlier candidate.
module corr_argmax
    import corr_pkg::*;
#(
    parameter int unsigned COORD_W = COORD_W_DEF,
    parameter int unsigned CORR_W  = CORR_W_DEF
) (
    input  logic               iCLK,
    input  logic               iRST_N,
    input  logic               iClear,
    input  logic               iValid,
    input  logic [COORD_W-1:0] iX,
    input  logic [COORD_W-1:0] iY,
    input  logic [CORR_W-1:0]  iScore,
    output logic [COORD_W-1:0] oBestX,
    output logic [COORD_W-1:0] oBestY,
    output logic [CORR_W-1:0]  oBestScore
);

    logic bestValid;

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            bestValid  <= 1'b0;
            oBestX     <= '0;
            oBestY     <= '0;
            oBestScore <= '0;
        end else if (iClear) begin
            bestValid  <= 1'b0;
            oBestX     <= '0;
            oBestY     <= '0;
            oBestScore <= '0;
        end else if (iValid && (!bestValid || (iScore > oBestScore))) begin
            bestValid  <= 1'b1;
            oBestX     <= iX;
            oBestY     <= iY;
            oBestScore <= iScore;
        end
    end

endmodule

// File: rtl/corr_search_sequencer.sv
// Walks the correlation engine over a search window in raster order with a programmable
// stride, tracks the best score and reports result, error and heartbeat status.
module corr_search_sequencer
    import corr_pkg::*;
#(
    parameter int unsigned COORD_W = COORD_W_DEF,
    parameter int unsigned CORR_W  = CORR_W_DEF,
    parameter int unsigned TMO_W   = 20,
    parameter int unsigned HB_W    = 24
) (
    input  logic               iCLK,
    input  logic               iRST_N,
    input  logic               iStart,
    input  logic               iAbort,
    input  logic [COORD_W-1:0] iWinX0,
    input  logic [COORD_W-1:0] iWinY0,
    input  logic [COORD_W-1:0] iWinX1,
    input  logic [COORD_W-1:0] iWinY1,
    input  logic [STEP_W-1:0]  iStep,
    output logic               oCorrStart,
    output logic [COORD_W-1:0] oX,
    output logic [COORD_W-1:0] oY,
    input  logic               iCorrValid,
    input  logic [CORR_W-1:0]  iCorrValue,
    output logic [COORD_W-1:0] oXresult,
    output logic [COORD_W-1:0] oYresult,
    output logic [CORR_W-1:0]  oBestCorr,
    output logic               oBusy,
    output logic               oFinished,
    output logic               oError,
    output logic               oStatusLed
);

    localparam int unsigned XW = COORD_W + 1;
    // Counter value in the last WAIT cycle; it would reach all-ones on the next edge.
    localparam logic [TMO_W-1:0] TMO_LAST = ~TMO_W'(1);

    stateT              state;
    logic [COORD_W-1:0] winX0;
    logic [COORD_W-1:0] winX1;
    logic [COORD_W-1:0] winY1;
    logic [STEP_W-1:0]  step;
    logic [TMO_W-1:0]   tmoCnt;
    logic [HB_W-1:0]    hbCnt;
    logic [XW-1:0]      nextX;
    logic [XW-1:0]      nextY;
    logic               startOk;
    logic               winBad;
    logic               argClear;
    logic               argValid;

    assign startOk  = iStart && ((state == IDLE) || (state == DONE));
    assign winBad   = (iWinX0 > iWinX1) || (iWinY0 > iWinY1);
    assign argClear = startOk && !iAbort;
    assign argValid = (state == WAIT) && iCorrValid && !iAbort;
    // One extra bit so stepping past the top coordinate cannot wrap back into the window.
    assign nextX    = {1'b0, oX} + XW'(step);
    assign nextY    = {1'b0, oY} + XW'(step);

    corr_argmax #(
        .COORD_W (COORD_W),
        .CORR_W  (CORR_W)
    ) uArgmax (
        .iCLK       (iCLK),
        .iRST_N     (iRST_N),
        .iClear     (argClear),
        .iValid     (argValid),
        .iX         (oX),
        .iY         (oY),
        .iScore     (iCorrValue),
        .oBestX     (oXresult),
        .oBestY     (oYresult),
        .oBestScore (oBestCorr)
    );

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state      <= IDLE;
            winX0      <= '0;
            winX1      <= '0;
            winY1      <= '0;
            step       <= '0;
            tmoCnt     <= '0;
            hbCnt      <= '0;
            oCorrStart <= 1'b0;
            oX         <= '0;
            oY         <= '0;
            oBusy      <= 1'b0;
            oFinished  <= 1'b0;
            oError     <= 1'b0;
            oStatusLed <= 1'b0;
        end else begin
            oCorrStart <= 1'b0;
            // Heartbeat; state transitions below override the LED when leaving busy.
            if (oBusy) begin
                hbCnt <= hbCnt + HB_W'(1);
                if (hbCnt == '1) begin
                    oStatusLed <= ~oStatusLed;
                end
            end
            if (iAbort) begin
                state      <= IDLE;
                oBusy      <= 1'b0;
                oFinished  <= 1'b0;
                oError     <= 1'b0;
                oStatusLed <= 1'b0;
            end else begin
                case (state)
                    IDLE, DONE: begin
                        if (iStart) begin
                            winX0 <= iWinX0;
                            winX1 <= iWinX1;
                            winY1 <= iWinY1;
                            step  <= stepNorm(iStep);
                            if (winBad) begin
                                state      <= DONE;
                                oBusy      <= 1'b0;
                                oFinished  <= 1'b1;
                                oError     <= 1'b1;
                                oStatusLed <= 1'b1;
                            end else begin
                                state      <= ISSUE;
                                oX         <= iWinX0;
                                oY         <= iWinY0;
                                oBusy      <= 1'b1;
                                oFinished  <= 1'b0;
                                oError     <= 1'b0;
                                oStatusLed <= 1'b0;
                                hbCnt      <= '0;
                            end
                        end
                    end
                    ISSUE: begin
                        oCorrStart <= 1'b1;
                        tmoCnt     <= '0;
                        state      <= WAIT;
                    end
                    WAIT: begin
                        if (iCorrValid) begin
                            state <= ADVANCE;
                        end else if (tmoCnt == TMO_LAST) begin
                            state      <= DONE;
                            oBusy      <= 1'b0;
                            oFinished  <= 1'b1;
                            oError     <= 1'b1;
                            oStatusLed <= 1'b1;
                        end else begin
                            tmoCnt <= tmoCnt + TMO_W'(1);
                        end
                    end
                    ADVANCE: begin
                        if (nextX <= {1'b0, winX1}) begin
                            oX    <= nextX[COORD_W-1:0];
                            state <= ISSUE;
                        end else begin
                            oX <= winX0;
                            if (nextY <= {1'b0, winY1}) begin
                                oY    <= nextY[COORD_W-1:0];
                                state <= ISSUE;
                            end else begin
                                state      <= DONE;
                                oBusy      <= 1'b0;
                                oFinished  <= 1'b1;
                                oError     <= 1'b0;
                                oStatusLed <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        state <= IDLE;
                        oBusy <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_corr_search_sequencer.sv
// Scoreboard bench: stimulus enumerates the expected candidates and argmax, a monitor checks
// every engine start and every completion against them, an engine model answers the handshakes.
`timescale 1ns/1ps
module tb_corr_search_sequencer;

    localparam int COORD_W = 13;
    localparam int CORR_W  = 32;
    localparam int TMO_W   = 4;
    localparam int HB_W    = 3;
    localparam int TMO_CYC = (1 << TMO_W) - 1;

    typedef struct {
        int x;
        int y;
    } cand_t;

    typedef struct {
        int          x;
        int          y;
        logic [31:0] score;
        int          err;
        int          kind;   // 0 normal end, 1 invalid window, 2 timeout
    } res_t;

    logic               iCLK = 1'b0;
    logic               iRST_N = 1'b0;
    logic               iStart = 1'b0;
    logic               stimAbort = 1'b0;
    logic               engAbort = 1'b0;
    logic               iAbort;
    logic [COORD_W-1:0] iWinX0 = '0;
    logic [COORD_W-1:0] iWinY0 = '0;
    logic [COORD_W-1:0] iWinX1 = '0;
    logic [COORD_W-1:0] iWinY1 = '0;
    logic [3:0]         iStep = '0;
    logic               engValid = 1'b0;
    logic               strayValid = 1'b0;
    logic [CORR_W-1:0]  engVal = '0;
    logic [CORR_W-1:0]  strayVal = '0;
    logic               iCorrValid;
    logic [CORR_W-1:0]  iCorrValue;
    logic               oCorrStart;
    logic [COORD_W-1:0] oX;
    logic [COORD_W-1:0] oY;
    logic [COORD_W-1:0] oXresult;
    logic [COORD_W-1:0] oYresult;
    logic [CORR_W-1:0]  oBestCorr;
    logic               oBusy;
    logic               oFinished;
    logic               oError;
    logic               oStatusLed;

    assign iAbort     = stimAbort | engAbort;
    assign iCorrValid = engValid | strayValid;
    assign iCorrValue = strayValid ? strayVal : engVal;

    corr_search_sequencer #(
        .COORD_W (COORD_W),
        .CORR_W  (CORR_W),
        .TMO_W   (TMO_W),
        .HB_W    (HB_W)
    ) dut (
        .iCLK       (iCLK),
        .iRST_N     (iRST_N),
        .iStart     (iStart),
        .iAbort     (iAbort),
        .iWinX0     (iWinX0),
        .iWinY0     (iWinY0),
        .iWinX1     (iWinX1),
        .iWinY1     (iWinY1),
        .iStep      (iStep),
        .oCorrStart (oCorrStart),
        .oX         (oX),
        .oY         (oY),
        .iCorrValid (iCorrValid),
        .iCorrValue (iCorrValue),
        .oXresult   (oXresult),
        .oYresult   (oYresult),
        .oBestCorr  (oBestCorr),
        .oBusy      (oBusy),
        .oFinished  (oFinished),
        .oError     (oError),
        .oStatusLed (oStatusLed)
    );

    always #5 iCLK = ~iCLK;

    int cyc = 0;
    always @(posedge iCLK) cyc <= cyc + 1;

    int          checks = 0;
    int          failures = 0;
    cand_t       expCand[$];
    res_t        expRes[$];
    logic [31:0] scoreArr[0:1023];
    int          searchId = 0;
    int          startCyc = 0;
    int          engLat = 0;
    int          engStall = -1;
    int          engAbortIdx = -1;
    int          csCount = 0;
    int          ledToggles = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge iCLK);
        #1;
    endtask

    // Engine model: answers each start after a latency, optionally stalling or aborting.
    initial begin
        int engId;
        int idx;
        int myIdx;
        int l;
        engId = -1;
        idx = 0;
        forever begin
            tick();
            if (oCorrStart && iRST_N) begin
                if (engId != searchId) begin
                    engId = searchId;
                    idx = 0;
                end
                myIdx = idx;
                idx++;
                if (myIdx != engStall) begin
                    l = (engLat < 0) ? int'($urandom_range(0, 3)) : engLat;
                    repeat (l) tick();
                    engVal   = scoreArr[myIdx];
                    engValid = 1'b1;
                    engAbort = (myIdx == engAbortIdx);
                    tick();
                    engValid = 1'b0;
                    engAbort = 1'b0;
                end
            end
        end
    end

    // Monitor: pops expected candidates on every start pulse and results on every completion.
    initial begin
        int    monId;
        bit    prevFin;
        bit    startPrev;
        bit    prevCs;
        bit    prevLed;
        bit    prevBusy;
        cand_t c;
        res_t  r;
        monId = 0;
        prevFin = 0;
        startPrev = 0;
        prevCs = 0;
        prevLed = 0;
        prevBusy = 0;
        forever begin
            @(negedge iCLK);
            if (!iRST_N) begin
                prevFin = 0;
                startPrev = 0;
                prevCs = 0;
                prevLed = 0;
                prevBusy = 0;
                continue;
            end
            if (oCorrStart) begin
                csCount++;
                check("corr_start_single_cycle", longint'(prevCs), 0);
                if (monId != searchId) begin
                    check("first_start_latency", cyc - startCyc, 2);
                    monId = searchId;
                end
                if (expCand.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_corr_start at x=%0d y=%0d required none", oX, oY);
                end else begin
                    c = expCand.pop_front();
                    check("cand_x", longint'(oX), c.x);
                    check("cand_y", longint'(oY), c.y);
                end
            end
            if (oBusy && prevBusy && (oStatusLed != prevLed)) ledToggles++;
            if (oFinished && (!prevFin || startPrev)) begin
                if (expRes.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_finish actual=1 required=0");
                end else begin
                    r = expRes.pop_front();
                    check("result_x", longint'(oXresult), r.x);
                    check("result_y", longint'(oYresult), r.y);
                    check("result_score", longint'(oBestCorr), longint'(r.score));
                    check("result_error", longint'(oError), r.err);
                    check("done_busy", longint'(oBusy), 0);
                    check("done_led", longint'(oStatusLed), 1);
                    if (r.kind == 1) check("invalid_done_latency", cyc - startCyc, 1);
                end
            end
            if (oCorrStart) startCyc = startCyc; // keeps startCyc read-only here
            prevFin = oFinished;
            startPrev = iStart;
            prevCs = oCorrStart;
            prevLed = oStatusLed;
            prevBusy = oBusy;
        end
    end

    // Timeout length: cycles from the last start pulse to the error completion.
    initial begin
        int lastCs;
        bit pf;
        lastCs = 0;
        pf = 0;
        forever begin
            @(negedge iCLK);
            if (oCorrStart) lastCs = cyc;
            if (iRST_N && oFinished && !pf && oError && (engStall >= 0) && (lastCs > startCyc))
                check("timeout_cycles", cyc - lastCs, TMO_CYC);
            pf = oFinished;
        end
    end

    task automatic runSearch(input int x0, input int y0, input int x1, input int y1,
                             input int stp, input int mode, input int cval, input int lat,
                             input int stallIdx, input int abortIdx, input bit midStart);
        int          s;
        int          n;
        int          lim;
        int          issued;
        int          bx;
        int          by;
        int          csBefore;
        int          ledBefore;
        logic [31:0] best;
        cand_t       cl[$];
        cand_t       c;
        res_t        r;
        bit          gotIt;
        s = (stp == 0) ? 1 : stp;
        if (x0 <= x1 && y0 <= y1)
            for (int y = y0; y <= y1; y += s)
                for (int x = x0; x <= x1; x += s) begin
                    c.x = x;
                    c.y = y;
                    cl.push_back(c);
                end
        n = cl.size();
        for (int i = 0; i < n; i++)
            scoreArr[i] = (mode == 0) ? 32'(10 * cl[i].y + cl[i].x) :
                          (mode == 1) ? 32'(cval) : 32'($urandom_range(0, 15));
        lim = n;
        if (stallIdx >= 0) lim = stallIdx;
        if (abortIdx >= 0) lim = abortIdx;
        bx = 0;
        by = 0;
        best = '0;
        for (int i = 0; i < lim; i++)
            if (i == 0 || scoreArr[i] > best) begin
                best = scoreArr[i];
                bx = cl[i].x;
                by = cl[i].y;
            end
        issued = (stallIdx >= 0) ? stallIdx + 1 : (abortIdx >= 0) ? abortIdx + 1 : n;
        for (int i = 0; i < issued; i++) expCand.push_back(cl[i]);
        if (abortIdx < 0) begin
            r.x = bx;
            r.y = by;
            r.score = best;
            r.kind = (n == 0) ? 1 : (stallIdx >= 0) ? 2 : 0;
            r.err = (r.kind != 0) ? 1 : 0;
            expRes.push_back(r);
        end
        engLat = lat;
        engStall = stallIdx;
        engAbortIdx = abortIdx;
        csBefore = csCount;
        ledBefore = ledToggles;
        iWinX0 = COORD_W'(x0);
        iWinY0 = COORD_W'(y0);
        iWinX1 = COORD_W'(x1);
        iWinY1 = COORD_W'(y1);
        iStep = 4'(stp);
        iStart = 1'b1;
        searchId++;
        startCyc = cyc;
        tick();
        iStart = 1'b0;
        if (midStart) begin
            repeat (4) tick();
            iWinX0 = COORD_W'(0);
            iWinX1 = COORD_W'(1);
            iWinY0 = COORD_W'(0);
            iWinY1 = COORD_W'(0);
            iStep = 4'd1;
            iStart = 1'b1;
            tick();
            iStart = 1'b0;
        end
        gotIt = 0;
        for (int i = 0; i < 5000; i++) begin
            if ((abortIdx >= 0) ? !oBusy : (expRes.size() == 0)) begin
                gotIt = 1;
                break;
            end
            tick();
        end
        check("search_completes_in_budget", longint'(gotIt), 1);
        if (abortIdx >= 0) begin
            tick();
            check("abort_result_x", longint'(oXresult), bx);
            check("abort_result_y", longint'(oYresult), by);
            check("abort_result_score", longint'(oBestCorr), longint'(best));
            check("abort_finished", longint'(oFinished), 0);
            check("abort_error", longint'(oError), 0);
            check("abort_led", longint'(oStatusLed), 0);
        end
        check("cands_remaining", expCand.size(), 0);
        check("corr_start_count", csCount - csBefore, issued);
        if (n >= 6 && abortIdx < 0 && stallIdx < 0)
            check("heartbeat_toggles", longint'(ledToggles > ledBefore), 1);
        expCand.delete();
        expRes.delete();
        tick();
    endtask

    task automatic checkAllZero(input string tag);
        check({tag, "_corr_start"}, longint'(oCorrStart), 0);
        check({tag, "_x"}, longint'(oX), 0);
        check({tag, "_y"}, longint'(oY), 0);
        check({tag, "_xres"}, longint'(oXresult), 0);
        check({tag, "_yres"}, longint'(oYresult), 0);
        check({tag, "_best"}, longint'(oBestCorr), 0);
        check({tag, "_busy"}, longint'(oBusy), 0);
        check({tag, "_finished"}, longint'(oFinished), 0);
        check({tag, "_error"}, longint'(oError), 0);
        check({tag, "_led"}, longint'(oStatusLed), 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog elapsed required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int x0;
        int y0;
        int x1;
        int y1;
        bit ok;
        repeat (3) tick();
        checkAllZero("in_reset");
        iRST_N = 1'b1;
        repeat (2) tick();
        checkAllZero("after_reset");

        // Stray score while idle must not disturb anything.
        strayVal = 32'hFFFF_FFFF;
        strayValid = 1'b1;
        tick();
        strayValid = 1'b0;
        repeat (2) tick();
        check("stray_idle_best", longint'(oBestCorr), 0);
        check("stray_idle_busy", longint'(oBusy), 0);

        runSearch(0, 0, 3, 2, 1, 0, 0, 5, -1, -1, 0);
        runSearch(0, 0, 4, 4, 2, 1, 7, 1, -1, -1, 0);
        runSearch(0, 0, 4, 4, 2, 1, 0, 0, -1, -1, 0);
        runSearch(5, 0, 2, 3, 1, 1, 0, 0, -1, -1, 0);
        runSearch(0, 0, 3, 1, 1, 2, 0, 5, 2, -1, 0);
        runSearch(1, 1, 4, 3, 1, 2, 0, -1, -1, 3, 0);

        // Stray score after abort, then confirm the held result did not move.
        x0 = int'(oXresult);
        y0 = int'(oYresult);
        x1 = int'(oBestCorr);
        strayVal = 32'hFFFF_FFFF;
        strayValid = 1'b1;
        tick();
        strayValid = 1'b0;
        repeat (2) tick();
        check("stray_after_abort_x", longint'(oXresult), x0);
        check("stray_after_abort_y", longint'(oYresult), y0);
        check("stray_after_abort_best", longint'(oBestCorr), x1);

        runSearch(0, 0, 2, 2, 1, 0, 0, 2, -1, -1, 0);
        runSearch(8190, 8190, 8191, 8191, 3, 2, 0, 1, -1, -1, 0);
        runSearch(2, 3, 6, 5, 1, 2, 0, 2, -1, -1, 1);

        for (int k = 0; k < 15; k++) begin
            x0 = int'($urandom_range(0, 30));
            y0 = int'($urandom_range(0, 30));
            x1 = x0 + int'($urandom_range(0, 8));
            y1 = y0 + int'($urandom_range(0, 8));
            if ($urandom_range(0, 7) == 0 && x0 > 0) x1 = x0 - 1;
            runSearch(x0, y0, x1, y1, int'($urandom_range(0, 4)), 2, 0, -1, -1, -1, 0);
        end

        // Reset while the engine is stalled in WAIT.
        scoreArr[0] = 32'd9;
        engLat = 1;
        engStall = 1;
        engAbortIdx = -1;
        cand_push: begin
            cand_t c;
            c.x = 1; c.y = 1; expCand.push_back(c);
            c.x = 2; c.y = 1; expCand.push_back(c);
        end
        iWinX0 = COORD_W'(1);
        iWinY0 = COORD_W'(1);
        iWinX1 = COORD_W'(2);
        iWinY1 = COORD_W'(2);
        iStep = 4'd1;
        iStart = 1'b1;
        searchId++;
        startCyc = cyc;
        tick();
        iStart = 1'b0;
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            if (expCand.size() == 0) begin
                ok = 1;
                break;
            end
            tick();
        end
        check("reset_test_reached_wait", longint'(ok), 1);
        repeat (3) tick();
        check("pre_reset_best", longint'(oBestCorr), 9);
        iRST_N = 1'b0;
        #1;
        checkAllZero("mid_wait_reset");
        tick();
        iRST_N = 1'b1;
        engStall = -1;
        tick();
        runSearch(0, 0, 3, 2, 1, 0, 0, 0, -1, -1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
